smem_read_loader: RTL and testbench

Receives the batch's read records from the AFU control FSM as a stream of 512-bit cache lines (`load_valid`/`load_data`) and stores them in an on-chip read RAM. Each read occupies four consecutive lines. The block asserts `read_load_done` once `batch_size`×4 lines have been captured, and serves the SMEM pipeline's per-line read-back requests. It sits directly downstream of the AFU core's LOAD_READ state, in the 200 MHz domain, and is reset per batch.

---
 rtl/smem_read_loader.sv | 208 ++++++++++++++++++++
 tb/tb_smem_read_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/smem_read_loader.sv
// smem_read_loader
// Captures a batch of read records (four 512-bit cache lines per read) into an
// on-chip read RAM, flags completion once batch_size*4 lines are stored, and
// serves per-line read-back requests for the SMEM pipeline.
// Optional build macro: SMEM_READ_LOADER_STATS_EN adds the load_cycles
// counter. Without it, load_cycles is tied to zero and no counter exists.
module smem_read_loader #(
    parameter int MAX_READ       = 64,
    parameter int READ_NUM_WIDTH = 6
) (
    input  logic                      Clk_32UI,
    input  logic                      reset_n,
    input  logic [READ_NUM_WIDTH:0]   batch_size,
    input  logic                      load_valid,
    input  logic [511:0]              load_data,
    output logic                      read_load_done,
    input  logic                      rd_en,
    input  logic [READ_NUM_WIDTH-1:0] rd_read_idx,
    input  logic [1:0]                rd_line,
    output logic [511:0]              rd_data,
    output logic                      rd_valid,
    output logic                      rd_hit,
    output logic                      overflow_err,
    output logic                      size_err,
    output logic [15:0]               load_cycles
);

    localparam int ADDR_W = READ_NUM_WIDTH + 2;
    localparam int CNT_W  = READ_NUM_WIDTH + 3;
    localparam int DEPTH  = MAX_READ * 4;
    localparam logic [READ_NUM_WIDTH:0] MAX_READ_W = (READ_NUM_WIDTH + 1)'(MAX_READ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic              size_err_q, size_err_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;

    logic [CNT_W-1:0]  line_cnt_inc;
    logic [CNT_W-1:0]  target_calc;
    logic              oversize;
    logic              last_line;

    logic              wr_en;
    logic              done_set;
    logic              overflow_set;

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit_d;
    logic              rd_valid_q, rd_hit_q, rd_seen_q;
    logic [511:0]      ram_rd_q;

    // Read RAM: no reset so it maps onto block RAM; contents survive resets.
    logic [511:0]      mem [DEPTH];

    // Batch sizes above MAX_READ are clamped; the line target is reads*4.
    assign oversize     = batch_size > MAX_READ_W;
    assign target_calc  = {(oversize ? MAX_READ_W : batch_size), 2'b00};
    assign line_cnt_inc = line_cnt_q + CNT_W'(1);
    assign last_line    = (line_cnt_inc == target_q);
    assign wr_addr      = line_cnt_q[ADDR_W-1:0];
    assign rd_addr      = {rd_read_idx, rd_line};

    // FSM state register
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE is a single-cycle setup state after each reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = (target_calc == '0) ? DONE : LOAD;
            LOAD: if (load_valid && last_line) state_d = DONE;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: write strobe and sticky-flag set conditions
    always_comb begin
        wr_en        = 1'b0;
        done_set     = 1'b0;
        overflow_set = 1'b0;
        case (state_q)
            IDLE: wr_en = load_valid;
            LOAD: begin
                wr_en    = load_valid;
                done_set = load_valid && last_line;
            end
            DONE: begin
                // Zero-target batches reach DONE straight from IDLE; done
                // then follows one edge later from here.
                done_set     = 1'b1;
                overflow_set = load_valid;
            end
            default: ;
        endcase
    end

    // Next-state values of the load bookkeeping registers
    always_comb begin
        line_cnt_d = wr_en ? line_cnt_inc : line_cnt_q;
        target_d   = (state_q == IDLE) ? target_calc : target_q;
        size_err_d = size_err_q | ((state_q == IDLE) & oversize);
        done_d     = done_q | done_set;
        overflow_d = overflow_q | overflow_set;
    end

    // Load bookkeeping registers
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt_q <= '0;
            target_q   <= '0;
            size_err_q <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            line_cnt_q <= line_cnt_d;
            target_q   <= target_d;
            size_err_q <= size_err_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // A hit needs the line already stored; a same-cycle write to the
    // requested line does not count because the RAM returns old contents.
    always_comb begin
        rd_hit_d = rd_en && ({1'b0, rd_addr} < line_cnt_q)
                   && !(wr_en && (wr_addr == rd_addr));
    end

    // Read-back status registers
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_hit_q   <= rd_hit_d;
            rd_seen_q  <= rd_seen_q | rd_en;
        end
    end

    // RAM write port
    always_ff @(posedge Clk_32UI) begin
        if (wr_en) begin
            mem[wr_addr] <= load_data;
        end
    end

    // RAM registered read port (read-before-write on address collision)
    always_ff @(posedge Clk_32UI) begin
        if (rd_en) begin
            ram_rd_q <= mem[rd_addr];
        end
    end

    // The RAM output register has no reset; mask it until the first
    // request after reset so rd_data starts at zero.
    assign rd_data        = rd_seen_q ? ram_rd_q : '0;
    assign rd_valid       = rd_valid_q;
    assign rd_hit         = rd_hit_q;
    assign read_load_done = done_q;
    assign overflow_err   = overflow_q;
    assign size_err       = size_err_q;

`ifdef SMEM_READ_LOADER_STATS_EN
    logic [15:0] load_cycles_q, load_cycles_d;

    // Count every cycle spent in LOAD, saturating; frozen once DONE is reached
    always_comb begin
        load_cycles_d = load_cycles_q;
        if ((state_q == LOAD) && (load_cycles_q != 16'hFFFF)) begin
            load_cycles_d = load_cycles_q + 16'd1;
        end
    end

    // Load-duration counter register
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            load_cycles_q <= 16'd0;
        end else begin
            load_cycles_q <= load_cycles_d;
        end
    end

    assign load_cycles = load_cycles_q;
`else
    assign load_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_smem_read_loader.sv
// Directed bench for smem_read_loader: a behavioural model tracks stored
// lines and sticky flags; read-back expectations go through a queue.
module tb_smem_read_loader;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [6:0]   batch_size = '0;
    logic         load_valid = 1'b0;
    logic [511:0] load_data = '0;
    logic         read_load_done;
    logic         rd_en = 1'b0;
    logic [5:0]   rd_read_idx = '0;
    logic [1:0]   rd_line = '0;
    logic [511:0] rd_data;
    logic         rd_valid;
    logic         rd_hit;
    logic         overflow_err;
    logic         size_err;
    logic [15:0]  load_cycles;

    always #5 clk = ~clk;

    smem_read_loader #(
        .MAX_READ       (64),
        .READ_NUM_WIDTH (6)
    ) dut (
        .Clk_32UI       (clk),
        .reset_n        (reset_n),
        .batch_size     (batch_size),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .read_load_done (read_load_done),
        .rd_en          (rd_en),
        .rd_read_idx    (rd_read_idx),
        .rd_line        (rd_line),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_hit         (rd_hit),
        .overflow_err   (overflow_err),
        .size_err       (size_err),
        .load_cycles    (load_cycles)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [511:0] data;
        bit           hit;
        bit           known;
        int           addr;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural model
    logic [511:0] shadow [256];
    bit           known  [256];
    int           m_cnt, m_target, m_state, m_bs;   // m_state: 0 IDLE, 1 LOAD, 2 DONE
    bit           m_done, m_ovf, m_size;

`ifdef SMEM_READ_LOADER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assert reset at a falling edge, check outputs asynchronously, release at the next one.
    task automatic do_reset(input int bs);
        reset_n    = 1'b0;
        load_valid = 1'b0;
        rd_en      = 1'b0;
        batch_size = 7'(bs);
        #1;
        chk("rst_done",  512'(read_load_done), 512'(0));
        chk("rst_valid", 512'(rd_valid), 512'(0));
        chk("rst_hit",   512'(rd_hit), 512'(0));
        chk("rst_ovf",   512'(overflow_err), 512'(0));
        chk("rst_size",  512'(size_err), 512'(0));
        chk("rst_data",  rd_data, 512'(0));
        chk("rst_cyc",   512'(load_cycles), 512'(0));
        exp_q.delete();
        m_bs     = bs;
        m_cnt    = 0;
        m_target = ((bs > 64) ? 64 : bs) * 4;
        m_state  = 0;
        m_done   = 0;
        m_ovf    = 0;
        m_size   = 0;
        @(negedge clk);
        chk("rst_hold_done", 512'(read_load_done), 512'(0));
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive inputs at a falling edge, model the rising edge, check at the next falling edge.
    task automatic drive(input bit lv, input logic [511:0] d, input bit re, input int addr);
        exp_t e;
        bit   wr;
        int   old_state;
        load_valid  = lv;
        load_data   = d;
        rd_en       = re;
        rd_read_idx = 6'(addr >> 2);
        rd_line     = 2'(addr & 3);
        if (re) begin
            e.addr  = addr;
            e.hit   = (addr < m_cnt);
            e.data  = shadow[addr];
            e.known = known[addr];
            exp_q.push_back(e);
        end
        wr = lv && (m_state != 2);
        if (lv && m_state == 2) m_ovf = 1;
        old_state = m_state;
        if (wr) begin
            shadow[m_cnt] = d;
            known[m_cnt]  = 1;
            m_cnt++;
        end
        case (old_state)
            0: begin
                m_size  = m_size | (m_bs > 64);
                m_state = (m_target == 0) ? 2 : 1;
            end
            1: if (wr && m_cnt == m_target) begin
                m_state = 2;
                m_done  = 1;
            end
            default: m_done = 1;
        endcase
        @(negedge clk);
        chk("done", 512'(read_load_done), 512'(m_done));
        chk("ovf",  512'(overflow_err), 512'(m_ovf));
        chk("size", 512'(size_err), 512'(m_size));
        chk("rd_valid", 512'(rd_valid), 512'(re));
        if (rd_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("read addr=%0d hit=%0b data=%0h", e.addr, rd_hit, rd_data[31:0]);
            chk("rd_hit", 512'(rd_hit), 512'(e.hit));
            if (e.known) chk("rd_data", rd_data, e.data);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) known[i] = 0;
        @(negedge clk);

        // Nominal batch: 2 reads, 8 back-to-back lines, data = line index
        do_reset(2);
        idle(1);
        for (int i = 0; i < 8; i++) drive(1'b1, 512'(i), (i == 5), 2);
        chk("nom_cycles", 512'(load_cycles), STATS ? 512'(8) : 512'(0));
        drive(1'b0, '0, 1'b1, 7);                 // {1,3}
        drive(1'b0, '0, 1'b1, 0);

        // Gapped input: lines every third cycle
        do_reset(1);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 512'(100 + i), 1'b0, 0);
            if (i < 3) idle(2);
        end
        chk("gap_cycles", 512'(load_cycles), STATS ? 512'(10) : 512'(0));
        drive(1'b0, '0, 1'b1, 2);
        drive(1'b0, '0, 1'b1, 4);                 // just past the batch: no hit
        idle(3);
        chk("gap_cycles_frozen", 512'(load_cycles), STATS ? 512'(10) : 512'(0));

        // Overflow: fifth line after done is dropped
        do_reset(1);
        idle(1);
        for (int i = 0; i < 5; i++) drive(1'b1, 512'(200 + i), 1'b0, 0);
        drive(1'b0, '0, 1'b1, 3);
        drive(1'b0, '0, 1'b1, 4);

        // Oversize: clamps to 256 lines; first line arrives in IDLE
        do_reset(100);
        for (int i = 0; i < 256; i++) drive(1'b1, 512'(1000 + i), 1'b0, 0);
        drive(1'b0, '0, 1'b1, 255);
        drive(1'b0, '0, 1'b1, 0);

        // Zero batch: done two edges after release, then overflow
        do_reset(0);
        idle(2);
        drive(1'b1, 512'(55), 1'b1, 0);
        idle(1);

        // Mid-load reset
        do_reset(1);
        idle(1);
        drive(1'b1, 512'(300), 1'b0, 0);
        drive(1'b1, 512'(301), 1'b0, 0);
        drive(1'b1, 512'(302), 1'b1, 0);
        do_reset(1);
        drive(1'b0, '0, 1'b1, 0);                 // stale line, no hit
        drive(1'b1, 512'(400), 1'b1, 0);          // collision: old data, no hit
        drive(1'b1, 512'(401), 1'b1, 0);
        drive(1'b1, 512'(402), 1'b0, 0);
        drive(1'b1, 512'(403), 1'b1, 3);          // collision on last line
        drive(1'b0, '0, 1'b1, 3);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
